// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR MAC engine and its coefficient ROM.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACCUM,
    DONE
  } fir_state_e;

  function automatic int unsigned fir_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator wide enough that NTAPS full-scale products cannot overflow.
  function automatic int unsigned fir_acc_w(input int unsigned dw, input int unsigned cw,
                                            input int unsigned ntaps);
    return dw + cw + fir_clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Coefficient ROM shared by all channels; synchronous read, one cycle of latency.
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter int    NTAPS     = 1023,
  parameter int    CW        = 16,
  parameter string COEF_FILE = "coef.hex",
  localparam int   AW        = fir_clog2(NTAPS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [CW-1:0] coef
);

  logic [CW-1:0] mem [NTAPS];
  logic [CW-1:0] coef_q;

  always_ff @(posedge clk) begin
    coef_q <= mem[addr];
  end

  assign coef = coef_q;

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR multiply-accumulate engine: one tap per cycle per pass,
// products registered before accumulation, saturated shifted result per channel.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int    NCH       = 2,
  parameter int    NTAPS     = 1023,
  parameter int    DW        = 16,
  parameter int    CW        = 16,
  parameter int    SHIFT     = 15,
  parameter string COEF_FILE = "coef.hex"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq,
  input  logic [NCH*DW-1:0] smpl_in,
  output logic [NCH*DW-1:0] smpl_out,
  output logic              valid,
  output logic              busy
);

  localparam int unsigned AW    = fir_clog2(NTAPS);
  localparam int unsigned TW    = fir_clog2(NTAPS + 1);
  localparam int unsigned ACC_W = fir_acc_w(DW, CW, NTAPS);
  localparam int unsigned PW    = DW + CW;

  localparam logic [AW-1:0] ADDR_LAST = AW'(NTAPS - 1);
  localparam logic [TW-1:0] TAP_END   = TW'(NTAPS);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  fir_state_e state_q, state_d;
  logic seq_q, seq_d;
  logic seq_armed_q, seq_armed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tap_q, tap_d;
  logic mul_vld_q, mul_vld_d;
  logic signed [PW-1:0] prod_q [NCH];
  logic signed [PW-1:0] prod_d [NCH];
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic [NCH*DW-1:0] out_q, out_d;
  logic [CW-1:0] rom_coef;
  logic rise;

  fir_coef_rom #(
    .NTAPS    (NTAPS),
    .CW       (CW),
    .COEF_FILE(COEF_FILE)
  ) u_rom (
    .clk (clk),
    .addr(addr_q),
    .coef(rom_coef)
  );

  function automatic logic [DW-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > OUT_MAX) return OUT_MAX[DW-1:0];
    else if (s < OUT_MIN) return OUT_MIN[DW-1:0];
    else return s[DW-1:0];
  endfunction

  // seq must be seen low after reset before an edge counts, so a level held across reset release is ignored.
  assign rise = seq & ~seq_q & seq_armed_q;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq;
    seq_armed_d = seq_armed_q | ~seq;
    addr_d      = addr_q;
    tap_d       = tap_q;
    mul_vld_d   = 1'b0;
    out_d       = out_q;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      prod_d[ch] = $signed(rom_coef) * $signed(smpl_in[ch*DW +: DW]);
      acc_d[ch]  = acc_q[ch] + (mul_vld_q ? {{(ACC_W-PW){prod_q[ch][PW-1]}}, prod_q[ch]} : '0);
    end

    case (state_q)
      IDLE: ;
      FILL: begin
        state_d = ACCUM;
        if (addr_q != ADDR_LAST) addr_d = addr_q + AW'(1);
      end
      ACCUM: begin
        // One extra cycle after the last tap drains the product register into the accumulators.
        if (tap_q == TAP_END) begin
          state_d = DONE;
          for (int unsigned ch = 0; ch < NCH; ch++) out_d[ch*DW +: DW] = sat_out(acc_d[ch]);
        end else begin
          mul_vld_d = 1'b1;
          tap_d     = tap_q + TW'(1);
          if (addr_q != ADDR_LAST) addr_d = addr_q + AW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rise) begin
      state_d   = FILL;
      addr_d    = '0;
      tap_d     = '0;
      mul_vld_d = 1'b0;
      out_d     = out_q;
      for (int unsigned ch = 0; ch < NCH; ch++) acc_d[ch] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seq_q       <= 1'b0;
      seq_armed_q <= 1'b0;
      addr_q      <= '0;
      tap_q       <= '0;
      mul_vld_q   <= 1'b0;
      out_q       <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        prod_q[ch] <= '0;
        acc_q[ch]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      seq_armed_q <= seq_armed_d;
      addr_q      <= addr_d;
      tap_q       <= tap_d;
      mul_vld_q   <= mul_vld_d;
      out_q       <= out_d;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        prod_q[ch] <= prod_d[ch];
        acc_q[ch]  <= acc_d[ch];
      end
    end
  end

  assign smpl_out = out_q;
  assign valid    = (state_q == DONE);
  assign busy     = (state_q == FILL) || (state_q == ACCUM);

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed and randomized passes against a
// behavioural dot-product model, plus abort and mid-pass reset scenarios.
module tb_fir_mac_engine;

  localparam int NCH   = 2;
  localparam int NTAPS = 4;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int SHIFT = 15;
  localparam longint OMAX = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (DW - 1));

  logic clk = 1'b0;
  logic rst_n;
  logic seq;
  logic [NCH*DW-1:0] smpl_in;
  logic [NCH*DW-1:0] smpl_out;
  logic valid;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic signed [CW-1:0] coef [NTAPS];
  logic signed [DW-1:0] xs [NCH][NTAPS];

  always #5 clk = ~clk;

  fir_mac_engine #(
    .NCH      (NCH),
    .NTAPS    (NTAPS),
    .DW       (DW),
    .CW       (CW),
    .SHIFT    (SHIFT),
    .COEF_FILE("")
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seq     (seq),
    .smpl_in (smpl_in),
    .smpl_out(smpl_out),
    .valid   (valid),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision dot product per channel, arithmetic shift, clamp.
  function automatic logic [NCH*DW-1:0] model();
    logic [NCH*DW-1:0] r;
    longint s;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      s = 0;
      for (int k = 0; k < NTAPS; k++) s += longint'(coef[k]) * longint'(xs[ch][k]);
      s = s >>> SHIFT;
      if (s > OMAX) s = OMAX;
      else if (s < OMIN) s = OMIN;
      r[ch*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic load_rom();
    for (int k = 0; k < NTAPS; k++) dut.u_rom.mem[k] = coef[k];
  endtask

  // restart_c >= 0 raises a second seq edge on the falling clock after cycle restart_c.
  task automatic run_pass(input string tag, input int restart_c, input bit hold_seq,
                          input logic [NCH*DW-1:0] exp_out);
    int c0;
    bit done;
    load_rom();
    @(negedge clk);
    seq  = 1'b1;
    c0   = 0;
    done = 1'b0;
    for (int c = 0; c < 4 * NTAPS + 16 && !done; c++) begin
      int rel;
      @(posedge clk);
      #1;
      rel = c - c0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (rel >= 1 && rel <= NTAPS) smpl_in[ch*DW +: DW] = xs[ch][rel-1];
        else smpl_in[ch*DW +: DW] = DW'($urandom);
      end
      check({tag, "_busy"}, busy, rel <= NTAPS + 1);
      check({tag, "_valid"}, valid, rel == NTAPS + 2);
      if (rel == NTAPS + 2) check({tag, "_out"}, smpl_out, exp_out);
      if (rel == NTAPS + 3) begin
        check({tag, "_hold"}, smpl_out, exp_out);
        done = 1'b1;
      end
      @(negedge clk);
      if (c == 0) seq = hold_seq;
      if (c == restart_c) begin
        seq = 1'b1;
        c0  = c + 1;
      end
    end
    check({tag, "_timeout"}, done, 1'b1);
    seq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    seq     = 1'b0;
    smpl_in = '0;
    #1;
    check("reset_valid", valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_out", smpl_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flat coefficients and samples: 4 * 0x4000*0x2000 >>> 15 = 0x4000.
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = 16'sh4000;
      xs[0][k] = 16'sh2000;
      xs[1][k] = 16'sh2000;
    end
    run_pass("flat", -1, 1'b0, {16'h4000, 16'h4000});
    check("flat_model", model(), {16'h4000, 16'h4000});

    // Positive and negative saturation.
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = 16'sh7FFF;
      xs[0][k] = 16'sh7FFF;
      xs[1][k] = 16'sh8000;
    end
    run_pass("sat", -1, 1'b0, {16'h8000, 16'h7FFF});

    // Tap alignment: impulse at tap 0 on ch0, tap 3 on ch1.
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = 16'(k + 1) <<< 11;
      xs[0][k] = (k == 0) ? 16'sh1000 : 16'sh0;
      xs[1][k] = (k == NTAPS - 1) ? 16'sh1000 : 16'sh0;
    end
    run_pass("align", -1, 1'b0, {16'h0400, 16'h0100});

    // Reset during ACCUM with seq held high across release.
    load_rom();
    @(negedge clk);
    seq = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_pre_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out", smpl_out, '0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * NTAPS + 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_valid", valid, 1'b0);
      check("rst_hold_busy", busy, 1'b0);
      check("rst_hold_out", smpl_out, '0);
    end
    @(negedge clk);
    seq = 1'b0;
    @(negedge clk);
    run_pass("after_rst", -1, 1'b0, {16'h0400, 16'h0100});

    // Abort at tap 2 with a second edge; only the restarted pass may report.
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = 16'($urandom);
      xs[0][k] = 16'($urandom) >>> 2;
      xs[1][k] = 16'($urandom) >>> 2;
    end
    run_pass("abort", 3, 1'b0, model());

    // Randomized passes, including held seq and random restart points.
    for (int it = 0; it < 6; it++) begin
      int rc;
      for (int k = 0; k < NTAPS; k++) begin
        coef[k] = 16'($urandom);
        xs[0][k] = (it % 2 == 0) ? 16'($urandom) : (16'($urandom) >>> 3);
        xs[1][k] = (it % 2 == 0) ? 16'($urandom) : (16'($urandom) >>> 3);
      end
      rc = (it == 3) ? int'($urandom_range(1, NTAPS + 1)) : -1;
      run_pass("rand", rc, it == 1, model());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
